padding_ctrl: RTL

Frame sequencer for the zero-padding stage. On a start pulse it walks the pad row counter from 0 to COUNT_MAX. For interior rows it fetches the matching source row from the line buffer. It then pulses the padding block's enable with the correct count and holds the padded row valid until downstream accepts it. It sits between the input line buffer and the first convolution layer, and is the only driver of the padding block's en/count inputs.

---
 rtl/padding_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/padding_ctrl.sv
// padding_ctrl: frame sequencer for the zero-padding stage.
// Walks the pad row counter 0..COUNT_MAX, fetches interior source rows from
// the line buffer, pulses the padding block enable with the row index and
// holds the padded row valid until downstream accepts it.
module padding_ctrl #(
  parameter int COUNT_MAX = 415,
  parameter int CNT_W     = 9,
  parameter int ADDR_W    = 9,
  parameter int ADDR_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  output logic              pad_en,
  output logic [CNT_W-1:0]  pad_count,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_row,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(COUNT_MAX);
  localparam logic [ADDR_W-1:0] ADDR_OFS  = ADDR_W'(ADDR_BASE);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  // Rows 0 and COUNT_MAX are all-zero border rows that need no source fetch.
  function automatic logic is_border(input logic [CNT_W-1:0] c);
    return (c == '0) || (c == CNT_LAST);
  endfunction

  // Interior row c (1..COUNT_MAX-1) maps to source row c-1 of the line buffer.
  function automatic logic [ADDR_W-1:0] src_addr(input logic [CNT_W-1:0] c);
    return ADDR_OFS + ADDR_W'(c) - ADDR_ONE;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                pad_en_q, pad_en_d;
  logic [CNT_W-1:0]    pad_count_q, pad_count_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    out_row_q, out_row_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state and row counter; abort pre-empts every non-idle state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Row 0 is a border row, so a frame starts directly at ISSUE.
          if (start && !abort) begin
            state_d = S_ISSUE;
            cnt_d   = '0;
          end
        end
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          if (rd_valid) begin
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: state_d = S_OUT;
        S_OUT: begin
          if (out_ready) begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_DONE;
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
              state_d = is_border(cnt_q + CNT_ONE) ? S_ISSUE : S_FETCH;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so every output is a flop that
  // is already valid in the first cycle of the state it belongs to.
  always_comb begin
    rd_req_d    = (state_d == S_FETCH);
    rd_addr_d   = rd_addr_q;
    pad_en_d    = (state_d == S_ISSUE);
    pad_count_d = pad_count_q;
    out_valid_d = (state_d == S_OUT);
    out_row_d   = out_row_q;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    if (state_d == S_FETCH) begin
      rd_addr_d = src_addr(cnt_d);
    end
    if (state_d == S_ISSUE) begin
      pad_count_d = cnt_d;
    end
    if (state_d == S_OUT) begin
      out_row_d = cnt_d;
    end
  end

  // State, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      pad_en_q    <= 1'b0;
      pad_count_q <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      pad_en_q    <= pad_en_d;
      pad_count_q <= pad_count_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign pad_en    = pad_en_q;
  assign pad_count = pad_count_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
